// File: rtl/otbn_pkg.sv
// otbn_pkg
//   Shared constants and types for the OTBN random number generator
//   (otbn_urnd_gen / otbn_urnd_chunk).
//   - UrndChunkLfsrWidth / UrndChunkLfsrCoeff : per-chunk Galois LFSR shape
//   - RndCnstUrndLfsrSeedDefault               : 256-bit default reset seed
//   - RndCnstUrndChunkLfsrPermDefault          : default output bit permutation
//   - urnd_gen_state_e                         : reseed controller states
package otbn_pkg;

    localparam int unsigned UrndChunkLfsrWidth = 64;
    localparam int unsigned UrndPermIdxWidth   = 6;

    // Galois right-shift feedback for taps 64, 63, 61, 60.
    localparam logic [UrndChunkLfsrWidth-1:0] UrndChunkLfsrCoeff = 64'hD800000000000000;

    // Every 64-bit chunk of the default seed is non-zero, so the zero-chunk
    // replacement path always lands on a valid LFSR state.
    localparam logic [4*UrndChunkLfsrWidth-1:0] RndCnstUrndLfsrSeedDefault = {
        64'h27D4EB2F165667C5,
        64'h165667B19E3779F9,
        64'hC2B2AE3D27D4EB4F,
        64'h9E3779B97F4A7C15
    };

    // Output bit i of a chunk is taken from state bit (13*i + 7) mod 64.
    // 13 is odd, so this is a bijection on 0..63.
    function automatic logic [UrndChunkLfsrWidth*UrndPermIdxWidth-1:0] gen_default_perm();
        logic [UrndChunkLfsrWidth*UrndPermIdxWidth-1:0] perm;
        perm = '0;
        for (int unsigned i = 0; i < UrndChunkLfsrWidth; i++) begin
            perm[i*UrndPermIdxWidth +: UrndPermIdxWidth] =
                UrndPermIdxWidth'((13 * i + 7) % UrndChunkLfsrWidth);
        end
        return perm;
    endfunction

    localparam logic [UrndChunkLfsrWidth*UrndPermIdxWidth-1:0] RndCnstUrndChunkLfsrPermDefault =
        gen_default_perm();

    typedef enum logic [1:0] {
        UrndGenUnseeded,
        UrndGenIdle,
        UrndGenReq
    } urnd_gen_state_e;

endpackage

// File: rtl/otbn_urnd_gen_if.sv
// otbn_urnd_gen_if
//   Groups the reseed handshake and the entropy (EDN) word handshake of
//   otbn_urnd_gen.
//   - reseed_req / reseed_ack : full reseed request and completion pulse
//   - edn_req / edn_ack       : entropy word request and per-word valid
//   - edn_data                : entropy word
//   master : the generator side; slave : the requester / entropy source side.
interface otbn_urnd_gen_if #(
    parameter int unsigned EdnWidth = 128
) ();

    logic                reseed_req;
    logic                reseed_ack;
    logic                edn_req;
    logic                edn_ack;
    logic [EdnWidth-1:0] edn_data;

    modport master (
        input  reseed_req,
        input  edn_ack,
        input  edn_data,
        output reseed_ack,
        output edn_req
    );

    modport slave (
        output reseed_req,
        output edn_ack,
        output edn_data,
        input  reseed_ack,
        input  edn_req
    );

endinterface

// File: rtl/otbn_urnd_chunk.sv
// otbn_urnd_chunk
//   One Galois LFSR chunk with parallel load, single step and a fixed output
//   bit permutation.
//   - clk_i, rst_i : clock, synchronous active-high reset (state <- Seed)
//   - load_i       : load load_data_i (takes priority over step_i)
//   - load_data_i  : value to load
//   - step_i       : s <= (s >> 1) ^ (s[0] ? Coeff : 0)
//   - state_o      : raw LFSR state
//   - rnd_o        : rnd_o[i] = state[Perm[i]]
module otbn_urnd_chunk
    import otbn_pkg::*;
#(
    parameter int unsigned                    Width = UrndChunkLfsrWidth,
    parameter logic [Width-1:0]               Coeff = UrndChunkLfsrCoeff,
    parameter logic [Width-1:0]               Seed  = RndCnstUrndLfsrSeedDefault[UrndChunkLfsrWidth-1:0],
    parameter logic [Width*$clog2(Width)-1:0] Perm  = RndCnstUrndChunkLfsrPermDefault
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_data_i,
    input  logic             step_i,
    output logic [Width-1:0] state_o,
    output logic [Width-1:0] rnd_o
);

    localparam int unsigned IdxW = $clog2(Width);

    logic [Width-1:0] state_q;
    logic [Width-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = load_data_i;
        end else if (step_i) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? Coeff : '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= Seed;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        rnd_o = '0;
        for (int unsigned i = 0; i < Width; i++) begin
            rnd_o[i] = state_q[Perm[i*IdxW +: IdxW]];
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/otbn_urnd_gen.sv
// otbn_urnd_gen
//   NChunks independent LFSR chunks, reseeded word by word from an entropy
//   source and stepped on demand.
//   - clk_i, rst_i          : clock, synchronous active-high reset
//   - reseed_req_i          : request a full reseed (ignored while reseeding)
//   - reseed_ack_o          : one-cycle pulse after the last entropy word
//   - edn_req_o             : high while entropy words are wanted
//   - edn_ack_i, edn_data_i : one entropy word per acked cycle
//   - advance_i             : step every chunk once (ignored while reseeding)
//   - rnd_o                 : permuted state of all chunks
//   - rnd_valid_o           : state derives from a completed reseed
//   - zero_err_o            : one-cycle pulse when an all-zero chunk was replaced
module otbn_urnd_gen
    import otbn_pkg::*;
#(
    parameter int unsigned                             ChunkWidth = UrndChunkLfsrWidth,
    parameter int unsigned                             NChunks    = 4,
    parameter int unsigned                             EdnWidth   = 128,
    parameter logic [ChunkWidth*NChunks-1:0]           LfsrSeed   = RndCnstUrndLfsrSeedDefault,
    parameter logic [ChunkWidth*$clog2(ChunkWidth)-1:0] LfsrPerm  = RndCnstUrndChunkLfsrPermDefault
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          reseed_req_i,
    output logic                          reseed_ack_o,
    output logic                          edn_req_o,
    input  logic                          edn_ack_i,
    input  logic [EdnWidth-1:0]           edn_data_i,
    input  logic                          advance_i,
    output logic [ChunkWidth*NChunks-1:0] rnd_o,
    output logic                          rnd_valid_o,
    output logic                          zero_err_o
);

    localparam int unsigned W        = ChunkWidth * NChunks;
    localparam int unsigned NWords   = W / EdnWidth;
    localparam int unsigned CntW     = (NWords > 1) ? $clog2(NWords) : 1;
    localparam logic [CntW-1:0] LastWord = CntW'(NWords - 1);

    urnd_gen_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            reseed_ack_q, reseed_ack_d;
    logic            zero_err_q, zero_err_d;

    logic [W-1:0]       state_all;
    logic [W-1:0]       assembled;
    logic [W-1:0]       load_data;
    logic [NChunks-1:0] chunk_zero;
    logic               word_ack;
    logic               final_ack;
    logic               step;
    int unsigned        word_base;

    // Each ack rewrites one word of the live state; the chunks are reloaded
    // with the whole merged vector so a word may straddle chunk boundaries.
    // On the final ack any chunk that would be all-zero (a stuck LFSR state)
    // falls back to its reset seed instead.
    always_comb begin
        word_ack  = (state_q == UrndGenReq) && edn_ack_i;
        final_ack = word_ack && (cnt_q == LastWord);
        step      = advance_i && (state_q != UrndGenReq);
        word_base = 32'(cnt_q) * EdnWidth;

        assembled = state_all;
        assembled[word_base +: EdnWidth] = edn_data_i;

        load_data  = assembled;
        chunk_zero = '0;
        for (int unsigned c = 0; c < NChunks; c++) begin
            chunk_zero[c] = (assembled[c*ChunkWidth +: ChunkWidth] == '0);
            if (final_ack && chunk_zero[c]) begin
                load_data[c*ChunkWidth +: ChunkWidth] = LfsrSeed[c*ChunkWidth +: ChunkWidth];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        reseed_ack_d = 1'b0;
        zero_err_d   = 1'b0;
        unique case (state_q)
            UrndGenUnseeded, UrndGenIdle: begin
                if (reseed_req_i) begin
                    state_d = UrndGenReq;
                    cnt_d   = '0;
                end
            end
            UrndGenReq: begin
                if (word_ack) begin
                    cnt_d = cnt_q + 1'b1;
                    if (final_ack) begin
                        state_d      = UrndGenIdle;
                        cnt_d        = '0;
                        reseed_ack_d = 1'b1;
                        zero_err_d   = |chunk_zero;
                    end
                end
            end
            default: begin
                state_d = UrndGenUnseeded;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= UrndGenUnseeded;
            cnt_q        <= '0;
            reseed_ack_q <= 1'b0;
            zero_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            reseed_ack_q <= reseed_ack_d;
            zero_err_q   <= zero_err_d;
        end
    end

    for (genvar c = 0; c < NChunks; c++) begin : g_chunk
        otbn_urnd_chunk #(
            .Width (ChunkWidth),
            .Coeff (UrndChunkLfsrCoeff),
            .Seed  (LfsrSeed[c*ChunkWidth +: ChunkWidth]),
            .Perm  (LfsrPerm)
        ) u_chunk (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .load_i      (word_ack),
            .load_data_i (load_data[c*ChunkWidth +: ChunkWidth]),
            .step_i      (step),
            .state_o     (state_all[c*ChunkWidth +: ChunkWidth]),
            .rnd_o       (rnd_o[c*ChunkWidth +: ChunkWidth])
        );
    end

    assign edn_req_o    = (state_q == UrndGenReq);
    assign rnd_valid_o  = (state_q == UrndGenIdle);
    assign reseed_ack_o = reseed_ack_q;
    assign zero_err_o   = zero_err_q;

endmodule
